// File: rtl/icache_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
// Holds the address/line/word types, the lookup FSM state type and the
// word-select helper used for both hit and fill responses.
package icache_pkg;

  localparam int unsigned AddrWidth   = 32;
  localparam int unsigned OffsetWidth = 4;   // 16-byte lines
  localparam int unsigned LineWidth   = 128;
  localparam int unsigned WordWidth   = 32;

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [LineWidth-1:0] line_t;
  typedef logic [WordWidth-1:0] word_t;

  typedef enum logic [1:0] {
    StIdle,
    StMiss,
    StResp
  } state_t;

  // Byte k of a line lives at [8k+7:8k], so word n is bytes 4n..4n+3.
  function automatic word_t line_word(input line_t line, input logic [1:0] sel);
    word_t w;
    case (sel)
      2'd0:    w = line[31:0];
      2'd1:    w = line[63:32];
      2'd2:    w = line[95:64];
      default: w = line[127:96];
    endcase
    return w;
  endfunction

  function automatic addr_t line_addr(input addr_t a);
    return {a[AddrWidth-1:OffsetWidth], {OffsetWidth{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetcher-side and mem_ctrler-side handshake bundle of the instruction cache.
// master: the cache (serves the fetcher, requests lines from mem_ctrler).
// slave:  the environment (fetcher plus mem_ctrler).
//   valid_from_fetcher/addr_from_fetcher/flush   fetch request and mispredict discard
//   inst_to_fetcher/ready_to_fetcher              delivered word and its one-cycle pulse
//   addr_to_mem_ctrler/valid_to_mem_ctrler        line request, held until ready
//   data_from_mem_ctrler/ready_from_mem_ctrler    fill line and its one-cycle pulse
interface icache_if;
  import icache_pkg::*;

  logic  valid_from_fetcher;
  addr_t addr_from_fetcher;
  logic  flush;
  word_t inst_to_fetcher;
  logic  ready_to_fetcher;
  addr_t addr_to_mem_ctrler;
  logic  valid_to_mem_ctrler;
  line_t data_from_mem_ctrler;
  logic  ready_from_mem_ctrler;

  modport master (
    input  valid_from_fetcher, addr_from_fetcher, flush,
    input  data_from_mem_ctrler, ready_from_mem_ctrler,
    output inst_to_fetcher, ready_to_fetcher,
    output addr_to_mem_ctrler, valid_to_mem_ctrler
  );

  modport slave (
    output valid_from_fetcher, addr_from_fetcher, flush,
    output data_from_mem_ctrler, ready_from_mem_ctrler,
    input  inst_to_fetcher, ready_to_fetcher,
    input  addr_to_mem_ctrler, valid_to_mem_ctrler
  );

endinterface

// File: rtl/icache_line_store.sv
// Tag, data and valid arrays of the direct-mapped cache.
//   clk, rst_n      clock; async active-low reset clears only the valid bits
//   i_rd_index      combinational read index
//   o_rd_valid/o_rd_tag/o_rd_line   read data for i_rd_index
//   i_wr_en, i_wr_index, i_wr_tag, i_wr_line   synchronous line install
module icache_line_store
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = 4,
  parameter int unsigned TAG_WIDTH   = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INDEX_WIDTH-1:0] i_rd_index,
  output logic                   o_rd_valid,
  output logic [TAG_WIDTH-1:0]   o_rd_tag,
  output line_t                  o_rd_line,
  input  logic                   i_wr_en,
  input  logic [INDEX_WIDTH-1:0] i_wr_index,
  input  logic [TAG_WIDTH-1:0]   i_wr_tag,
  input  line_t                  i_wr_line
);

  localparam int unsigned Lines = 2 ** INDEX_WIDTH;

  logic [Lines-1:0]     r_valid;
  logic [TAG_WIDTH-1:0] r_tag  [Lines];
  line_t                r_data [Lines];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  // Tag/data contents are meaningless while the valid bit is clear, so no reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_line;
    end
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_line  = r_data[i_rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache between the fetcher and mem_ctrler.
// A hit answers one cycle after the request; a miss requests one 16-byte line,
// installs it, then answers from the latched fill word.
//   clk, rst_n   clock; async active-low reset
//   rdy          global enable; all state and outputs hold while low
//   bus          icache_if.master (fetcher and mem_ctrler handshakes)
//   hit_count, miss_count   only with ICACHE_PERF_EN defined: accepted lookups
module icache
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  icache_if.master    bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned TagWidth = AddrWidth - INDEX_WIDTH - OffsetWidth;

  state_t r_state;
  logic   r_drop;
  logic   r_ready;
  word_t  r_inst;
  logic   r_mem_valid;
  addr_t  r_mem_addr;
  logic [1:0] r_word_sel;
  word_t  r_fill_word;

  logic [INDEX_WIDTH-1:0] w_index;
  logic [TagWidth-1:0]    w_tag;
  logic                   w_rd_valid;
  logic [TagWidth-1:0]    w_rd_tag;
  line_t                  w_rd_line;
  logic                   w_hit;
  logic                   w_accept;
  logic                   w_fill;
  logic                   w_unused;

  assign w_index  = bus.addr_from_fetcher[INDEX_WIDTH+OffsetWidth-1:OffsetWidth];
  assign w_tag    = bus.addr_from_fetcher[AddrWidth-1:INDEX_WIDTH+OffsetWidth];
  assign w_hit    = w_rd_valid && (w_rd_tag == w_tag);
  // No new lookup while the previous pulse is still on the bus.
  assign w_accept = (r_state == StIdle) && bus.valid_from_fetcher && !bus.flush && !r_ready;
  assign w_fill   = rdy && (r_state == StMiss) && bus.ready_from_mem_ctrler;
  assign w_unused = ^bus.addr_from_fetcher[1:0];

  icache_line_store #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TagWidth)
  ) u_line_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd_index (w_index),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_line  (w_rd_line),
    .i_wr_en    (w_fill),
    .i_wr_index (r_mem_addr[INDEX_WIDTH+OffsetWidth-1:OffsetWidth]),
    .i_wr_tag   (r_mem_addr[AddrWidth-1:INDEX_WIDTH+OffsetWidth]),
    .i_wr_line  (bus.data_from_mem_ctrler)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_drop      <= 1'b0;
      r_ready     <= 1'b0;
      r_inst      <= '0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_word_sel  <= '0;
      r_fill_word <= '0;
    end else if (rdy) begin
      r_ready <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            if (w_hit) begin
              r_ready <= 1'b1;
              r_inst  <= line_word(w_rd_line, bus.addr_from_fetcher[3:2]);
            end else begin
              r_state     <= StMiss;
              r_mem_valid <= 1'b1;
              r_mem_addr  <= line_addr(bus.addr_from_fetcher);
              r_word_sel  <= bus.addr_from_fetcher[3:2];
              r_drop      <= 1'b0;
            end
          end
        end
        StMiss: begin
          // The line transaction cannot be aborted; a flush only suppresses the reply.
          if (bus.flush) begin
            r_drop <= 1'b1;
          end
          if (bus.ready_from_mem_ctrler) begin
            r_mem_valid <= 1'b0;
            r_fill_word <= line_word(bus.data_from_mem_ctrler, r_word_sel);
            r_state     <= StResp;
          end
        end
        StResp: begin
          if (!r_drop && !bus.flush) begin
            r_ready <= 1'b1;
            r_inst  <= r_fill_word;
          end
          r_drop  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.ready_to_fetcher    = r_ready;
  assign bus.inst_to_fetcher     = r_inst;
  assign bus.valid_to_mem_ctrler = r_mem_valid;
  assign bus.addr_to_mem_ctrler  = r_mem_addr;

`ifdef ICACHE_PERF_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (rdy && w_accept) begin
      if (w_hit) begin
        r_hit_count <= r_hit_count + 32'd1;
      end else begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache.sv
module tb_icache;
  import icache_pkg::*;

  logic clk;
  logic rst_n;
  logic rdy;
  icache_if bus ();
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache #(
    .INDEX_WIDTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .bus   (bus)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout t=%0t", name, $time);
  endtask

  // Backing memory: byte k of line A is (k + A[11:4]*0x13) mod 256, so line 0x1000 holds 0..15.
  function automatic line_t mem_line(input addr_t a);
    line_t l;
    logic [7:0] base;
    base = a[11:4] * 8'h13;
    for (int k = 0; k < 16; k++) l[8*k +: 8] = base + 8'(k);
    return l;
  endfunction

  // Addresses span 3 tags x 16 lines so both hits and conflicts are frequent.
  function automatic addr_t rand_addr();
    addr_t a;
    a = 32'h0000_1000;
    a[9:8] = 2'($urandom_range(0, 2));
    a[7:4] = 4'($urandom_range(0, 15));
    a[3:2] = 2'($urandom_range(0, 3));
    a[1:0] = 2'($urandom_range(0, 3));
    return a;
  endfunction

  // Reference model: cache contents as arrays plus one outstanding-miss record.
  logic        m_valid [16];
  logic [23:0] m_tag   [16];
  line_t       m_data  [16];
  bit          m_busy, m_filled, m_drop, e_ready;
  addr_t       m_req_line;
  int          m_sel;
  word_t       m_fill_word, e_inst;
  int unsigned e_hits, e_misses;

  always @(posedge clk or negedge rst_n) begin
    int    idx;
    addr_t a;
    bit    nr;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      m_busy = 0; m_filled = 0; m_drop = 0; e_ready = 0;
      e_inst = '0; m_req_line = '0; m_sel = 0; m_fill_word = '0;
      e_hits = 0; e_misses = 0;
    end else if (rdy) begin
      nr  = 0;
      a   = bus.addr_from_fetcher;
      idx = int'(a[7:4]);
      if (!m_busy) begin
        if (bus.valid_from_fetcher && !bus.flush && !e_ready) begin
          if (m_valid[idx] && m_tag[idx] == a[31:8]) begin
            nr = 1;
            e_inst = m_data[idx][32*int'(a[3:2]) +: 32];
            e_hits++;
          end else begin
            m_busy = 1;
            m_req_line = {a[31:4], 4'h0};
            m_sel = int'(a[3:2]);
            m_drop = 0;
            e_misses++;
          end
        end
      end else if (!m_filled) begin
        if (bus.flush) m_drop = 1;
        if (bus.ready_from_mem_ctrler) begin
          idx = int'(m_req_line[7:4]);
          m_valid[idx] = 1'b1;
          m_tag[idx]   = m_req_line[31:8];
          m_data[idx]  = bus.data_from_mem_ctrler;
          m_fill_word  = bus.data_from_mem_ctrler[32*m_sel +: 32];
          m_filled = 1;
        end
      end else begin
        if (!m_drop && !bus.flush) begin
          nr = 1;
          e_inst = m_fill_word;
        end
        m_busy = 0; m_filled = 0; m_drop = 0;
      end
      e_ready = nr;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("m_ready", {31'd0, bus.ready_to_fetcher}, {31'd0, e_ready});
    chk("m_mem_valid", {31'd0, bus.valid_to_mem_ctrler}, {31'd0, m_busy && !m_filled});
    if (e_ready) chk("m_inst", bus.inst_to_fetcher, e_inst);
    if (m_busy && !m_filled) chk("m_mem_addr", bus.addr_to_mem_ctrler, m_req_line);
`ifdef ICACHE_PERF_EN
    chk("m_hit_count", hit_count, e_hits);
    chk("m_miss_count", miss_count, e_misses);
`endif
  end

  task automatic wait_mem_valid(input string name);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.valid_to_mem_ctrler) return;
    end
    timeout(name);
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.ready_to_fetcher) return;
    end
    timeout(name);
  endtask

  task automatic give_fill(input addr_t line);
    bus.ready_from_mem_ctrler = 1'b1;
    bus.data_from_mem_ctrler  = mem_line(line);
    @(negedge clk);
    bus.ready_from_mem_ctrler = 1'b0;
  endtask

  task automatic check_zero(input string name);
    chk({name, "_ready"}, {31'd0, bus.ready_to_fetcher}, 32'd0);
    chk({name, "_inst"}, bus.inst_to_fetcher, 32'd0);
    chk({name, "_mem_valid"}, {31'd0, bus.valid_to_mem_ctrler}, 32'd0);
    chk({name, "_mem_addr"}, bus.addr_to_mem_ctrler, 32'd0);
`ifdef ICACHE_PERF_EN
    chk({name, "_hits"}, hit_count, 32'd0);
    chk({name, "_misses"}, miss_count, 32'd0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int    pulses;
    bit    f_pending;
    bit    fl_last;
    rst_n = 1'b0;
    rdy   = 1'b1;
    bus.valid_from_fetcher    = 1'b0;
    bus.addr_from_fetcher     = '0;
    bus.flush                 = 1'b0;
    bus.ready_from_mem_ctrler = 1'b0;
    bus.data_from_mem_ctrler  = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Cold miss, then a back-to-back hit on the same line.
    @(negedge clk);
    bus.valid_from_fetcher = 1'b1;
    bus.addr_from_fetcher  = 32'h0000_1008;
    @(negedge clk);
    chk("cold_mem_valid", {31'd0, bus.valid_to_mem_ctrler}, 32'd1);
    chk("cold_mem_addr", bus.addr_to_mem_ctrler, 32'h0000_1000);
    chk("cold_no_ready", {31'd0, bus.ready_to_fetcher}, 32'd0);
    give_fill(32'h0000_1000);
    chk("cold_mem_drop", {31'd0, bus.valid_to_mem_ctrler}, 32'd0);
    @(negedge clk);
    chk("cold_ready", {31'd0, bus.ready_to_fetcher}, 32'd1);
    chk("cold_inst", bus.inst_to_fetcher, 32'h0B0A_0908);
    bus.addr_from_fetcher = 32'h0000_100C;
    @(negedge clk);
    chk("b2b_gap", {31'd0, bus.ready_to_fetcher}, 32'd0);
    @(negedge clk);
    chk("hit_ready", {31'd0, bus.ready_to_fetcher}, 32'd1);
    chk("hit_inst", bus.inst_to_fetcher, 32'h0F0E_0D0C);
    chk("hit_no_mem", {31'd0, bus.valid_to_mem_ctrler}, 32'd0);
    bus.valid_from_fetcher = 1'b0;

    // Conflict on index 0 evicts 0x1000.
    @(negedge clk);
    bus.valid_from_fetcher = 1'b1;
    bus.addr_from_fetcher  = 32'h0000_1100;
    @(negedge clk);
    chk("conf_mem_valid", {31'd0, bus.valid_to_mem_ctrler}, 32'd1);
    chk("conf_mem_addr", bus.addr_to_mem_ctrler, 32'h0000_1100);
    give_fill(32'h0000_1100);
    wait_ready("conf_ready");
    chk("conf_inst", bus.inst_to_fetcher, 32'h3332_3130);
    bus.addr_from_fetcher = 32'h0000_1000;
    wait_mem_valid("refetch_miss");
    chk("refetch_mem_addr", bus.addr_to_mem_ctrler, 32'h0000_1000);
    give_fill(32'h0000_1000);
    wait_ready("refetch_ready");
    chk("refetch_inst", bus.inst_to_fetcher, 32'h0302_0100);
    bus.valid_from_fetcher = 1'b0;

    // Flush two cycles into a miss: line installed, no pulse.
    @(negedge clk);
    bus.valid_from_fetcher = 1'b1;
    bus.addr_from_fetcher  = 32'h0000_1240;
    @(negedge clk);
    chk("fl_mem_valid", {31'd0, bus.valid_to_mem_ctrler}, 32'd1);
    @(negedge clk);
    bus.flush = 1'b1;
    bus.valid_from_fetcher = 1'b0;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("fl_mem_hold", {31'd0, bus.valid_to_mem_ctrler}, 32'd1);
    give_fill(32'h0000_1240);
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.ready_to_fetcher) pulses++;
    end
    chk("fl_no_ready", pulses, 32'd0);
    chk("fl_mem_idle", {31'd0, bus.valid_to_mem_ctrler}, 32'd0);
    bus.valid_from_fetcher = 1'b1;
    bus.addr_from_fetcher  = 32'h0000_1244;
    @(negedge clk);
    chk("fl_hit_ready", {31'd0, bus.ready_to_fetcher}, 32'd1);
    chk("fl_hit_inst", bus.inst_to_fetcher, 32'hB3B2_B1B0);
    chk("fl_hit_no_mem", {31'd0, bus.valid_to_mem_ctrler}, 32'd0);
    bus.valid_from_fetcher = 1'b0;

    // rdy low for 5 cycles mid-miss; a ready pulse during the stall is ignored.
    @(negedge clk);
    bus.valid_from_fetcher = 1'b1;
    bus.addr_from_fetcher  = 32'h0000_1280;
    wait_mem_valid("stall_miss");
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.ready_from_mem_ctrler = (i == 2);
      bus.data_from_mem_ctrler  = mem_line(32'h0000_1280);
      @(negedge clk);
      chk("stall_mem_valid", {31'd0, bus.valid_to_mem_ctrler}, 32'd1);
      chk("stall_mem_addr", bus.addr_to_mem_ctrler, 32'h0000_1280);
    end
    bus.ready_from_mem_ctrler = 1'b0;
    rdy = 1'b1;
    @(negedge clk);
    chk("stall_still_miss", {31'd0, bus.valid_to_mem_ctrler}, 32'd1);
    give_fill(32'h0000_1280);
    wait_ready("stall_ready");
    chk("stall_inst", bus.inst_to_fetcher, 32'hFBFA_F9F8);
    bus.valid_from_fetcher = 1'b0;

    // Asynchronous reset mid-miss, then the same address misses again.
    @(negedge clk);
    bus.valid_from_fetcher = 1'b1;
    bus.addr_from_fetcher  = 32'h0000_12C0;
    wait_mem_valid("arst_miss");
    #2 rst_n = 1'b0;
    #1 check_zero("arst");
    @(negedge clk);
    rst_n = 1'b1;
    wait_mem_valid("arst_remiss");
    chk("arst_remiss_addr", bus.addr_to_mem_ctrler, 32'h0000_12C0);
    give_fill(32'h0000_12C0);
    wait_ready("arst_ready");
    chk("arst_inst", bus.inst_to_fetcher, 32'h4746_4544);
    bus.valid_from_fetcher = 1'b0;

    // Randomized traffic against the model.
    f_pending = 0;
    fl_last   = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (bus.ready_to_fetcher || fl_last) f_pending = 0;
      rdy       = ($urandom_range(0, 7) != 0);
      bus.flush = rdy && ($urandom_range(0, 19) == 0);
      fl_last   = bus.flush;
      if (!f_pending) begin
        if ($urandom_range(0, 3) != 0) begin
          bus.valid_from_fetcher = 1'b1;
          bus.addr_from_fetcher  = rand_addr();
          f_pending = 1;
        end else begin
          bus.valid_from_fetcher = 1'b0;
        end
      end
      bus.ready_from_mem_ctrler = bus.valid_to_mem_ctrler && ($urandom_range(0, 2) == 0);
      bus.data_from_mem_ctrler  = mem_line(bus.addr_to_mem_ctrler);
    end
    @(negedge clk);
    rdy = 1'b1;
    bus.flush = 1'b0;
    bus.valid_from_fetcher = 1'b0;
    bus.ready_from_mem_ctrler = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
